// File: rtl/custom_mem_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// custom_mem_rr_arbiter_if
//   Bundle of mem-protocol lanes. The arbiter uses one instance with N lanes
//   on its requester side and one instance with N=1 on its bridge side.
//
//   Handshake: a master raises req[i] with addr/we/wdata/be for lane i and
//   holds them stable until gnt[i] is seen high in the same cycle (req and
//   gnt both high = request accepted). Exactly one valid[i] pulse per accepted
//   request returns the response; rdata/error are shared by all lanes and
//   are meaningful only in a cycle where some valid bit is high.
//
//   Signals (per lane i, packed at [i*W +: W]):
//     req, addr, we, wdata, be   master -> slave
//     gnt, valid                 slave  -> master (one bit per lane)
//     rdata, error               slave  -> master (shared)
// ---------------------------------------------------------------------------
interface custom_mem_rr_arbiter_if #(
    parameter int N  = 1,
    parameter int AW = 32,
    parameter int DW = 32
);
    localparam int BE_W = DW / 8;

    logic [N-1:0]      req;
    logic [N*AW-1:0]   addr;
    logic [N-1:0]      we;
    logic [N*DW-1:0]   wdata;
    logic [N*BE_W-1:0] be;
    logic [N-1:0]      gnt;
    logic [N-1:0]      valid;
    logic [DW-1:0]     rdata;
    logic              error;

    modport master (
        output req, addr, we, wdata, be,
        input  gnt, valid, rdata, error
    );

    modport slave (
        input  req, addr, we, wdata, be,
        output gnt, valid, rdata, error
    );
endinterface

// File: rtl/custom_mem_rr_arbiter.sv
// ---------------------------------------------------------------------------
// custom_mem_rr_arbiter
//   Round-robin arbiter sharing one mem master port (towards the mem->AXI4
//   bridge) among NUM_REQ mem requesters, one transaction in flight at a time.
//   FSM: IDLE (arbitrate, 1 cycle) -> REQ (forward, wait bridge grant)
//        -> WAIT_RSP (wait bridge response, route it to owner) -> IDLE.
//
//   Optional build macro MEM_ARB_TIMEOUT_EN: adds a response watchdog that
//   returns an error response to the owner after TIMEOUT_CYCLES cycles in
//   WAIT_RSP. Without it WAIT_RSP waits indefinitely.
//
//   Ports:
//     clk_i      clock, rising edge
//     rst_i      synchronous reset, active-high
//     s_mem      requester side (slave modport, NUM_REQ lanes)
//     m_mem      bridge side (master modport, 1 lane)
//     busy_o     high in REQ or WAIT_RSP
//     owner_o    index of current/last owner
//     state_o    FSM state (debug)
//     rr_ptr_o   round-robin pointer (debug)
// ---------------------------------------------------------------------------
module custom_mem_rr_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int MEM_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    custom_mem_rr_arbiter_if.slave     s_mem,
    custom_mem_rr_arbiter_if.master    m_mem,
    output logic                       busy_o,
    output logic [$clog2(NUM_REQ)-1:0] owner_o,
    output logic [1:0]                 state_o,
    output logic [$clog2(NUM_REQ)-1:0] rr_ptr_o
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int AW    = MEM_ADDR_WIDTH;
    localparam int DW    = MEM_DATA_WIDTH;
    localparam int BE_W  = DW / 8;

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT_RSP = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   next_ptr;
    logic               found;
    int                 idx;
    logic               timeout;

    logic [NUM_REQ-1:0] gnt, valid;
    logic [DW-1:0]      rdata;
    logic               error;
    logic               m_req, m_we;
    logic [AW-1:0]      m_addr;
    logic [DW-1:0]      m_wdata;
    logic [BE_W-1:0]    m_be;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cfg
        $error("TIMEOUT_CYCLES must be >= 1");
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] timer_q;

    // Timer holds 0 outside WAIT_RSP, so it is cleared on entry; it fires
    // on the TIMEOUT_CYCLES-th WAIT_RSP cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i || state_q != WAIT_RSP) timer_q <= '0;
        else                              timer_q <= timer_q + 1'b1;
    end

    assign timeout = (state_q == WAIT_RSP) && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // First requesting index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
    always_comb begin
        pick  = rr_ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!found && s_mem.req[idx]) begin
                found = 1'b1;
                pick  = IDX_W'(idx);
            end
        end
    end

    assign next_ptr = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        gnt      = '0;
        valid    = '0;
        rdata    = '0;
        error    = 1'b0;
        m_req    = 1'b0;
        m_addr   = '0;
        m_we     = 1'b0;
        m_wdata  = '0;
        m_be     = '0;
        unique case (state_q)
            IDLE: begin
                // Bridge responses here are spurious and simply not routed.
                if (|s_mem.req) begin
                    owner_d = pick;
                    state_d = REQ;
                end
            end
            REQ: begin
                m_req   = s_mem.req[owner_q];
                m_addr  = s_mem.addr[int'(owner_q)*AW +: AW];
                m_we    = s_mem.we[owner_q];
                m_wdata = s_mem.wdata[int'(owner_q)*DW +: DW];
                m_be    = s_mem.be[int'(owner_q)*BE_W +: BE_W];
                if (!s_mem.req[owner_q]) begin
                    // Owner withdrew before grant; pointer stays put.
                    state_d = IDLE;
                end else if (m_mem.gnt[0]) begin
                    gnt[owner_q] = 1'b1;
                    state_d      = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (m_mem.valid[0]) begin
                    valid[owner_q] = 1'b1;
                    rdata          = m_mem.rdata;
                    error          = m_mem.error;
                    rr_ptr_d       = next_ptr;
                    state_d        = IDLE;
                end else if (timeout) begin
                    valid[owner_q] = 1'b1;
                    error          = 1'b1;
                    rr_ptr_d       = next_ptr;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign s_mem.gnt   = gnt;
    assign s_mem.valid = valid;
    assign s_mem.rdata = rdata;
    assign s_mem.error = error;
    assign m_mem.req   = m_req;
    assign m_mem.addr  = m_addr;
    assign m_mem.we    = m_we;
    assign m_mem.wdata = m_wdata;
    assign m_mem.be    = m_be;

    assign busy_o   = (state_q != IDLE);
    assign owner_o  = owner_q;
    assign state_o  = state_q;
    assign rr_ptr_o = rr_ptr_q;
endmodule

// File: tb/tb_custom_mem_rr_arbiter.sv
module tb_custom_mem_rr_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int IW = 2;
    localparam int SW = IW + DW + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    custom_mem_rr_arbiter_if #(.N(N), .AW(AW), .DW(DW)) s_if ();
    custom_mem_rr_arbiter_if #(.N(1), .AW(AW), .DW(DW)) m_if ();

    logic          busy;
    logic [IW-1:0] owner, rr_ptr;
    logic [1:0]    state;

    custom_mem_rr_arbiter #(
        .NUM_REQ(N), .MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk), .rst_i(rst), .s_mem(s_if), .m_mem(m_if),
        .busy_o(busy), .owner_o(owner), .state_o(state), .rr_ptr_o(rr_ptr)
    );

    int total = 0;
    int bad   = 0;
    logic [SW-1:0] exp_q[$];

    logic [AW-1:0] drv_addr[N];
    logic          drv_we[N];
    logic [DW-1:0] drv_wdata[N];
    logic [BW-1:0] drv_be[N];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int r, input logic [AW-1:0] a, input logic w,
                           input logic [DW-1:0] d, input logic [BW-1:0] b);
        drv_addr[r] = a; drv_we[r] = w; drv_wdata[r] = d; drv_be[r] = b;
        s_if.addr[r*AW +: AW] = a;
        s_if.we[r]            = w;
        s_if.wdata[r*DW +: DW] = d;
        s_if.be[r*BW +: BW]   = b;
        s_if.req[r]           = 1'b1;
    endtask

    // One bridge transaction for the expected owner: grant after gnt_wait REQ
    // cycles, response rsp_lat cycles after the grant cycle.
    task automatic serve(input int exp_own, input logic [DW-1:0] rsp, input logic err,
                         input int gnt_wait, input int rsp_lat, input bit drop, input bit junk);
        bit seen;
        logic [SW-1:0] e;
        logic [N-1:0] exp_oh;
        seen = 1'b0;
        for (int w = 0; w < 8 && !seen; w++) begin
            @(negedge clk); #1;
            if (m_if.req[0] === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++; $display("FAIL req_wait owner=%0d: m_mem_req never rose", exp_own);
        end else begin
            total++;
            if (owner !== IW'(exp_own)) begin
                bad++; $display("FAIL owner got=%0d exp=%0d", owner, exp_own);
            end
            total++;
            if ({m_if.addr, m_if.we, m_if.wdata, m_if.be} !==
                {drv_addr[exp_own], drv_we[exp_own], drv_wdata[exp_own], drv_be[exp_own]}) begin
                bad++; $display("FAIL fwd got=%h/%b/%h/%b exp=%h/%b/%h/%b", m_if.addr, m_if.we, m_if.wdata,
                                m_if.be, drv_addr[exp_own], drv_we[exp_own], drv_wdata[exp_own], drv_be[exp_own]);
            end
            for (int k = 0; k < gnt_wait; k++) begin
                @(negedge clk); #1;
                total++;
                if (s_if.gnt !== '0 || s_if.valid !== '0 || m_if.req[0] !== 1'b1) begin
                    bad++; $display("FAIL pre_gnt gnt=%b valid=%b m_req=%b exp 0000/0000/1", s_if.gnt, s_if.valid, m_if.req);
                end
            end
            m_if.gnt = 1'b1;
            if (junk) begin m_if.valid = 1'b1; m_if.rdata = 32'h5EED_5EED; end
            #1;
            exp_oh = '0; exp_oh[exp_own] = 1'b1;
            total++;
            if (s_if.gnt !== exp_oh || s_if.valid !== '0) begin
                bad++; $display("FAIL gnt got=%b valid=%b exp=%b/0000", s_if.gnt, s_if.valid, exp_oh);
            end
            exp_q.push_back({IW'(exp_own), rsp, err});
            @(negedge clk);
            m_if.gnt = 1'b0; m_if.valid = 1'b0; m_if.rdata = '0;
            if (drop) s_if.req[exp_own] = 1'b0;
            #1;
            total++;
            if (s_if.gnt !== '0 || m_if.req[0] !== 1'b0 || busy !== 1'b1) begin
                bad++; $display("FAIL wait_state gnt=%b m_req=%b busy=%b exp 0000/0/1", s_if.gnt, m_if.req, busy);
            end
            for (int k = 1; k < rsp_lat; k++) begin
                @(negedge clk); #1;
                total++;
                if (s_if.valid !== '0 || s_if.gnt !== '0) begin
                    bad++; $display("FAIL early_rsp valid=%b gnt=%b exp 0", s_if.valid, s_if.gnt);
                end
            end
            m_if.valid = 1'b1; m_if.rdata = rsp; m_if.error = err;
            #1;
            total++;
            if (exp_q.size() == 0) begin
                bad++; $display("FAIL rsp: scoreboard empty, valid=%b", s_if.valid);
            end else begin
                e = exp_q.pop_front();
                exp_oh = '0; exp_oh[e[SW-1 -: IW]] = 1'b1;
                if ({s_if.valid, s_if.rdata, s_if.error} !== {exp_oh, e[DW:1], e[0]}) begin
                    bad++; $display("FAIL rsp got=%b/%h/%b exp=%b/%h/%b", s_if.valid, s_if.rdata, s_if.error,
                                    exp_oh, e[DW:1], e[0]);
                end
            end
            @(negedge clk);
            m_if.valid = 1'b0; m_if.rdata = '0; m_if.error = 1'b0;
            #1;
            total++;
            if (rr_ptr !== IW'((exp_own + 1) % N) || busy !== 1'b0 || s_if.valid !== '0) begin
                bad++; $display("FAIL post_rsp rr_ptr=%0d busy=%b valid=%b exp %0d/0/0", rr_ptr, busy, s_if.valid,
                                (exp_own + 1) % N);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        total++;
        if ({s_if.gnt, s_if.valid, s_if.rdata, s_if.error} !== '0) begin
            bad++; $display("FAIL reset_s gnt=%b valid=%b rdata=%h err=%b exp 0", s_if.gnt, s_if.valid, s_if.rdata, s_if.error);
        end
        total++;
        if ({m_if.req, m_if.addr, m_if.we, m_if.wdata, m_if.be} !== '0) begin
            bad++; $display("FAIL reset_m req=%b addr=%h exp 0", m_if.req, m_if.addr);
        end
        total++;
        if ({busy, owner, rr_ptr, state} !== '0) begin
            bad++; $display("FAIL reset_ctl busy=%b owner=%0d rr_ptr=%0d state=%0d exp 0", busy, owner, rr_ptr, state);
        end
        rst = 1'b0;
    endtask

    task automatic test_all_requesters();
        int order[5] = '{0, 1, 2, 3, 0};
        for (int r = 0; r < N; r++)
            set_req(r, $urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
        for (int t = 0; t < 5; t++)
            serve(order[t], $urandom, 1'b0, $urandom_range(0, 2), $urandom_range(1, 3), 1'b0, 1'b0);
        s_if.req = '0;
    endtask

    task automatic test_single();
        set_req(2, 32'h0000_1000, 1'b0, 32'h0, 4'hF);
        serve(2, 32'hCAFE_F00D, 1'b0, 1, 3, 1'b1, 1'b0);
    endtask

    task automatic test_wrap();
        set_req(0, 32'h0000_2000, 1'b0, 32'h0, 4'hF);
        set_req(3, 32'h0000_3000, 1'b0, 32'h0, 4'hF);
        serve(3, 32'h3333_3333, 1'b0, 0, 1, 1'b1, 1'b0);
        serve(0, 32'h0000_0000, 1'b0, 0, 2, 1'b1, 1'b0);
    endtask

    task automatic test_write_error();
        set_req(1, 32'h0000_4444, 1'b1, 32'hA5A5_A5A5, 4'b0011);
        serve(1, 32'h0000_0000, 1'b1, 1, 2, 1'b1, 1'b0);
    endtask

    task automatic test_abort();
        set_req(0, 32'h0000_5000, 1'b0, 32'h0, 4'hF);
        @(negedge clk); #1;
        total++;
        if (m_if.req[0] !== 1'b1 || owner !== 2'd0) begin
            bad++; $display("FAIL abort_req m_req=%b owner=%0d exp 1/0", m_if.req, owner);
        end
        s_if.req[0] = 1'b0;
        #1;
        total++;
        if (m_if.req[0] !== 1'b0) begin
            bad++; $display("FAIL abort_drop m_req=%b exp 0", m_if.req);
        end
        @(negedge clk); #1;
        total++;
        if (busy !== 1'b0 || rr_ptr !== 2'd2 || s_if.gnt !== '0) begin
            bad++; $display("FAIL abort_idle busy=%b rr_ptr=%0d gnt=%b exp 0/2/0000", busy, rr_ptr, s_if.gnt);
        end
    endtask

    task automatic test_spurious();
        m_if.valid = 1'b1; m_if.rdata = 32'h1234_5678; m_if.error = 1'b1;
        #1;
        total++;
        if (s_if.valid !== '0 || s_if.rdata !== '0 || s_if.error !== 1'b0) begin
            bad++; $display("FAIL spur_idle valid=%b rdata=%h err=%b exp 0", s_if.valid, s_if.rdata, s_if.error);
        end
        m_if.error = 1'b0;
        set_req(1, 32'h0000_6000, 1'b0, 32'h0, 4'hF);
        serve(1, 32'h0BAD_BEEF, 1'b0, 1, 2, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid();
        set_req(3, 32'h0000_7000, 1'b0, 32'h0, 4'hF);
        @(negedge clk); m_if.gnt = 1'b1;
        @(negedge clk); m_if.gnt = 1'b0; s_if.req[3] = 1'b0; #1;
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL rmid_busy got=%b exp 1", busy);
        end
        rst = 1'b1;
        @(negedge clk); #1;
        total++;
        if (busy !== 1'b0 || rr_ptr !== '0 || owner !== '0) begin
            bad++; $display("FAIL rmid_rst busy=%b rr_ptr=%0d owner=%0d exp 0", busy, rr_ptr, owner);
        end
        rst = 1'b0;
        @(negedge clk);
        m_if.valid = 1'b1; m_if.rdata = 32'hDEAD_0001; #1;
        total++;
        if (s_if.valid !== '0 || s_if.rdata !== '0 || busy !== 1'b0 || rr_ptr !== '0) begin
            bad++; $display("FAIL rmid_late valid=%b rdata=%h busy=%b rr_ptr=%0d exp 0", s_if.valid, s_if.rdata, busy, rr_ptr);
        end
        @(negedge clk); m_if.valid = 1'b0; m_if.rdata = '0;
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [SW-1:0] e;
        set_req(0, 32'h0000_8000, 1'b0, 32'h0, 4'hF);
        @(negedge clk); m_if.gnt = 1'b1;
        exp_q.push_back({2'd0, 32'h0, 1'b1});
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk); m_if.gnt = 1'b0; s_if.req[0] = 1'b0; #1;
            total++;
            if (k < 8) begin
                if (s_if.valid !== '0) begin
                    bad++; $display("FAIL tmo_early k=%0d valid=%b exp 0000", k, s_if.valid);
                end
            end else if (exp_q.size() == 0) begin
                bad++; $display("FAIL tmo: scoreboard empty");
            end else begin
                e = exp_q.pop_front();
                if ({s_if.valid, s_if.rdata, s_if.error} !== {4'b0001, e[DW:1], e[0]}) begin
                    bad++; $display("FAIL tmo got=%b/%h/%b exp=0001/%h/%b", s_if.valid, s_if.rdata, s_if.error, e[DW:1], e[0]);
                end
            end
        end
        @(negedge clk); m_if.valid = 1'b1; m_if.rdata = 32'hFEED_0002; #1;
        total++;
        if (s_if.valid !== '0 || rr_ptr !== 2'd1) begin
            bad++; $display("FAIL tmo_late valid=%b rr_ptr=%0d exp 0000/1", s_if.valid, rr_ptr);
        end
        @(negedge clk); m_if.valid = 1'b0; m_if.rdata = '0;
    endtask
`endif

    initial begin
        s_if.req = '0; s_if.addr = '0; s_if.we = '0; s_if.wdata = '0; s_if.be = '0;
        m_if.gnt = '0; m_if.valid = '0; m_if.rdata = '0; m_if.error = 1'b0;
        test_reset();
        test_all_requesters();
        test_single();
        test_wrap();
        test_write_error();
        test_abort();
        test_spurious();
        test_reset_mid();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
